// File: rtl/mul_sched_pkg.sv
// mul_sched_pkg
//   Shared types and helpers for the multiplier scheduler.
//   - state_t : scheduler FSM states (IDLE, RUN, DONE)
//   - rr_next : round-robin next-grant search over a valid vector
package mul_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Widest requester vector the helper supports (NREQ <= 16).
    localparam int RR_MAX = 16;

    // Returns {found, index}. The search starts at ptr+1 and wraps modulo
    // nreq. Iterating downward lets the nearest candidate overwrite any
    // farther one, so no early loop exit is needed.
    function automatic logic [4:0] rr_next(input logic [RR_MAX-1:0] valid,
                                           input logic [3:0]        ptr,
                                           input int                nreq);
        logic [4:0] res;
        logic [3:0] idx;
        res = '0;
        for (int k = nreq; k >= 1; k--) begin
            idx = 4'((int'(ptr) + k) % nreq);
            if (valid[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/mul_seq_core.sv
// mul_seq_core
//   Sequential shift-add unsigned multiplier, one multiplier bit per cycle.
//   Ports:
//     clk, rst  : clock, asynchronous active-high reset
//     start     : load a_in/b_in, clear accumulator and counter
//     run       : perform one shift-add step this cycle
//     a_in,b_in : N-bit unsigned operands
//     last      : high during the final run step
//     prod      : 2N-bit accumulator (final product once last has been seen)
//   Optional feature: MUL_SCHED_EARLY_EXIT_EN ends the run once the remaining
//   multiplier bits are all zero.
module mul_seq_core #(
    parameter int N = 32
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           run,
    input  logic [N-1:0]   a_in,
    input  logic [N-1:0]   b_in,
    output logic           last,
    output logic [2*N-1:0] prod
);

    localparam int CW = $clog2(N);

    logic [N-1:0]   a_q, a_d;
    logic [N-1:0]   mreg_q, mreg_d;
    logic [2*N-1:0] acc_q, acc_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [N-1:0]   mreg_shr;

    always_comb begin
        a_d      = a_q;
        mreg_d   = mreg_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        mreg_shr = mreg_q >> 1;
        if (start) begin
            a_d    = a_in;
            mreg_d = b_in;
            acc_d  = '0;
            cnt_d  = '0;
        end else if (run) begin
            if (mreg_q[0]) begin
                acc_d = acc_q + ({{N{1'b0}}, a_q} << cnt_q);
            end
            mreg_d = mreg_shr;
            cnt_d  = cnt_q + CW'(1);
        end
    end

`ifdef MUL_SCHED_EARLY_EXIT_EN
    assign last = run && ((cnt_q == CW'(N - 1)) || (mreg_shr == '0));
`else
    assign last = run && (cnt_q == CW'(N - 1));
`endif

    assign prod = acc_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q    <= '0;
            mreg_q <= '0;
            acc_q  <= '0;
            cnt_q  <= '0;
        end else begin
            a_q    <= a_d;
            mreg_q <= mreg_d;
            acc_q  <= acc_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/mul_sched.sv
// mul_sched
//   Round-robin scheduler sharing one sequential multiplier between NREQ
//   requesters.
//   Ports:
//     clk, rst   : clock, asynchronous active-high reset
//     req_valid  : per-requester operand valid
//     req_ready  : per-requester accept strobe (one-hot or zero)
//     req_a/b    : packed operands, requester i at [i*N +: N]
//     rsp_valid  : product available
//     rsp_ready  : consumer accepts product
//     rsp_id     : requester owning rsp_prod
//     rsp_prod   : 2N-bit unsigned product
//     busy       : high outside IDLE
//   Optional feature: MUL_SCHED_EARLY_EXIT_EN (see mul_seq_core).
module mul_sched
    import mul_sched_pkg::*;
#(
    parameter int N    = 32,
    parameter int NREQ = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*N-1:0]     req_a,
    input  logic [NREQ*N-1:0]     req_b,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [$clog2(NREQ)-1:0] rsp_id,
    output logic [2*N-1:0]        rsp_prod,
    output logic                  busy
);

    localparam int IDW = $clog2(NREQ);

    state_t         state_q, state_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [IDW-1:0] id_q, id_d;
    logic [4:0]     pick;
    logic [IDW-1:0] grant_id;
    logic           start;
    logic           run;
    logic           last;
    logic [2*N-1:0] prod;

    always_comb begin
        pick     = rr_next(RR_MAX'(req_valid), 4'(ptr_q), NREQ);
        grant_id = IDW'(pick[3:0]);
        state_d   = state_q;
        ptr_d     = ptr_q;
        id_d      = id_q;
        req_ready = '0;
        start     = 1'b0;
        run       = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick[4]) begin
                    req_ready[grant_id] = 1'b1;
                    start               = 1'b1;
                    id_d                = grant_id;
                    state_d             = RUN;
                end
            end
            RUN: begin
                run = 1'b1;
                if (last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                // The pointer moves only on the response handshake so the
                // next search starts just after the requester just served.
                if (rsp_ready) begin
                    ptr_d   = id_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= IDW'(NREQ - 1);
            id_q    <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
        end
    end

    mul_seq_core #(.N(N)) u_core (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .run   (run),
        .a_in  (req_a[grant_id*N +: N]),
        .b_in  (req_b[grant_id*N +: N]),
        .last  (last),
        .prod  (prod)
    );

    assign rsp_valid = (state_q == DONE);
    assign rsp_id    = id_q;
    assign rsp_prod  = prod;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mul_sched.sv
module tb_mul_sched;

    localparam int N    = 8;
    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic                 clk;
    logic                 rst;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*N-1:0]    req_a;
    logic [NREQ*N-1:0]    req_b;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [IDW-1:0]       rsp_id;
    logic [2*N-1:0]       rsp_prod;
    logic                 busy;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Reference model: a transaction is either absent, counting down its
    // run time, or waiting (timer==0) for the consumer.
    bit m_busy;
    int m_timer;
    int m_prod;
    int m_id;
    int m_ptr;
    int grants[$];
    int gcyc[$];

    mul_sched #(.N(N), .NREQ(NREQ)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_prod  (rsp_prod),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int runlen(input int b);
`ifdef MUL_SCHED_EARLY_EXIT_EN
        int bl = 0;
        for (int i = 0; i < N; i++) if (b[i]) bl = i + 1;
        return (bl < 1) ? 1 : bl;
`else
        return N;
`endif
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_busy  = 0;
        m_timer = 0;
        m_prod  = 0;
        m_id    = 0;
        m_ptr   = NREQ - 1;
    endtask

    task automatic set_op(input int i, input int a, input int b);
        req_a[i*N +: N] = N'(a);
        req_b[i*N +: N] = N'(b);
    endtask

    // One clock: check outputs against the model, advance the model, cross the edge.
    task automatic step();
        int w;
        bit found;
        logic [NREQ-1:0] er;
        #1;
        found = 0;
        w     = 0;
        for (int k = 1; k <= NREQ; k++) begin
            int idx;
            idx = (m_ptr + k) % NREQ;
            if (!found && req_valid[idx]) begin
                found = 1;
                w     = idx;
            end
        end
        er = '0;
        if (!m_busy && found) er[w] = 1'b1;
        chk("req_ready", 64'(req_ready), 64'(er));
        chk("busy", 64'(busy), 64'(m_busy));
        chk("rsp_valid", 64'(rsp_valid), 64'(m_busy && m_timer == 0));
        if (m_busy && m_timer == 0) begin
            chk("rsp_id", 64'(rsp_id), 64'(m_id));
            chk("rsp_prod", 64'(rsp_prod), 64'(m_prod));
        end
        if (!m_busy) begin
            if (found) begin
                int a, b;
                a = int'(req_a[w*N +: N]);
                b = int'(req_b[w*N +: N]);
                m_busy  = 1;
                m_timer = runlen(b);
                m_prod  = a * b;
                m_id    = w;
                grants.push_back(w);
                gcyc.push_back(cyc);
            end
        end else if (m_timer > 0) begin
            m_timer--;
        end else if (rsp_ready) begin
            m_busy = 0;
            m_ptr  = m_id;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_until_idle(input int max);
        int n = 0;
        while (m_busy && n < max) begin
            step();
            n++;
        end
        chk("idle_timeout", 64'(m_busy), 64'(0));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_req_ready", 64'(req_ready), 64'(0));
        chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("rst_rsp_id", 64'(rsp_id), 64'(0));
        chk("rst_rsp_prod", 64'(rsp_prod), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic measure(input int a, input int b, input int exp_lat, input string tag);
        int lat = 0;
        bit seen = 0;
        req_valid = '0;
        set_op(0, a, b);
        req_valid[0] = 1'b1;
        step();
        req_valid = '0;
        for (int i = 1; i <= 40 && !seen; i++) begin
            if (rsp_valid) begin
                seen = 1;
                lat  = i;
            end else begin
                step();
            end
        end
        chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        chk({tag, "_prod"}, 64'(rsp_prod), 64'(a * b));
        run_until_idle(40);
    endtask

    initial begin
        int cnt2;
        int el0, el5;
        rst       = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        do_reset();

        // 1: single request 0xFF*0xFF from requester 0
        set_op(0, 8'hFF, 8'hFF);
        req_valid = 4'b0001;
        step();
        req_valid = '0;
        for (int i = 0; i < N; i++) step();
        chk("t1_rsp_valid", 64'(rsp_valid), 64'(1));
        chk("t1_prod", 64'(rsp_prod), 64'h0000_FE01);
        chk("t1_id", 64'(rsp_id), 64'(0));
        run_until_idle(20);

        // 2: all requesters continuously valid, round-robin order from reset
        do_reset();
        grants.delete();
        gcyc.delete();
        set_op(0, 3, 5);
        set_op(1, 7, 9);
        set_op(2, 200, 2);
        set_op(3, 0, 17);
        req_valid = 4'b1111;
        for (int i = 0; i < 5 * (N + 2); i++) step();
        req_valid = '0;
        run_until_idle(40);
        chk("t2_ngrants", 64'(grants.size()), 64'(5));
        if (grants.size() >= 5) begin
            chk("t2_g0", 64'(grants[0]), 64'(0));
            chk("t2_g1", 64'(grants[1]), 64'(1));
            chk("t2_g2", 64'(grants[2]), 64'(2));
            chk("t2_g3", 64'(grants[3]), 64'(3));
            chk("t2_g4", 64'(grants[4]), 64'(0));
            chk("t2_interval", 64'(gcyc[1] - gcyc[0]), 64'(runlen(5) + 2));
        end

        // 3: response stall for 20 cycles while others wait
        rsp_ready = 1'b0;
        set_op(0, 11, 13);
        set_op(3, 6, 7);
        req_valid = 4'b1001;
        for (int i = 0; i < N + 1; i++) step();
        for (int i = 0; i < 20; i++) step();
        rsp_ready = 1'b1;
        grants.delete();
        gcyc.delete();
        step();
        step();
        chk("t3_regrant", 64'(grants.size()), 64'(1));
        req_valid = '0;
        run_until_idle(40);

        // 4: asynchronous reset mid-run, then requester 0 beats requester 3
        set_op(1, 45, 99);
        req_valid = 4'b0010;
        step();
        req_valid = '0;
        for (int i = 0; i < 3; i++) step();
        do_reset();
        grants.delete();
        set_op(0, 2, 3);
        set_op(3, 4, 5);
        req_valid = 4'b1001;
        step();
        req_valid = '0;
        run_until_idle(40);
        chk("t4_first", 64'(grants.size() > 0 ? grants[0] : -1), 64'(0));

        // 5: requester 2 valid for one cycle while requester 1 is granted
        grants.delete();
        set_op(1, 10, 10);
        set_op(2, 20, 20);
        req_valid = 4'b0110;
        step();
        req_valid = '0;
        run_until_idle(40);
        step();
        step();
        cnt2 = 0;
        foreach (grants[i]) if (grants[i] == 2) cnt2++;
        chk("t5_no_id2", 64'(cnt2), 64'(0));
        chk("t5_ngrants", 64'(grants.size()), 64'(1));

        // 6: operand-dependent latency
`ifdef MUL_SCHED_EARLY_EXIT_EN
        el0 = 2;
        el5 = 4;
`else
        el0 = 9;
        el5 = 9;
`endif
        measure(8'h37, 0, el0, "t6_b0");
        measure(9, 5, el5, "t6_b5");
        measure(8'hC3, 8'h80, 9, "t6_b80");

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            for (int r = 0; r < NREQ; r++) begin
                req_valid[r] = ($urandom_range(0, 2) == 0);
                set_op(r, int'($urandom_range(0, 255)),
                       int'($urandom_range(0, 255) >> $urandom_range(0, 7)));
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        run_until_idle(60);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
